// File: rtl/gamepad_pmod_pkg.sv
// Shared constants and types for the gamepad PMOD demo.
package gamepad_pmod_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CTRL_BITS  = 12;

    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    typedef logic [CTRL_BITS-1:0] ctrl_word_t;

    localparam ctrl_word_t ABSENT_WORD = 12'hFFF;

endpackage

// File: rtl/gamepad_pmod_rx.sv
// Gamepad PMOD serial receiver: sync, edge detect, shift, capture.
// Optional absent-timeout enabled by GAMEPAD_TIMEOUT_EN.
module gamepad_pmod_rx
    import gamepad_pmod_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pmod_latch,
    input  logic       pmod_clk,
    input  logic       pmod_data,
    output ctrl_word_t ctrl1_word,
    output ctrl_word_t ctrl2_word,
    output logic       heartbeat
);

    logic [2:0]            sync1;
    logic [2:0]            sync2;
    logic [2:0]            dly;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;
    logic                  latch_rise;
    logic                  clk_rise;
    logic                  frame_ok;

    assign latch_rise = sync2[2] & ~dly[2];
    assign clk_rise   = sync2[1] & ~dly[1];
    assign frame_ok   = latch_rise && (bit_cnt == 5'(FRAME_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            dly   <= '0;
        end else begin
            sync1 <= {pmod_latch, pmod_clk, pmod_data};
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

`ifdef GAMEPAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Latch has priority: a clk edge in the same cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ctrl1_word <= ABSENT_WORD;
            ctrl2_word <= ABSENT_WORD;
            heartbeat  <= 1'b0;
`ifdef GAMEPAD_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
`ifdef GAMEPAD_TIMEOUT_EN
            if (frame_ok) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_cnt     <= '0;
                ctrl1_word <= ABSENT_WORD;
                ctrl2_word <= ABSENT_WORD;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
`endif
            if (latch_rise) begin
                bit_cnt <= '0;
                if (frame_ok) begin
                    ctrl2_word <= shift_reg[23:12];
                    ctrl1_word <= shift_reg[11:0];
                    heartbeat  <= ~heartbeat;
                end
            end else if (clk_rise) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], sync2[0]};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gamepad_pmod_demo.sv
// Gamepad PMOD demo tile: selects one controller and maps its buttons.
// Optional absent-timeout enabled by GAMEPAD_TIMEOUT_EN.
module gamepad_pmod_demo
    import gamepad_pmod_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    ctrl_word_t ctrl1_word;
    ctrl_word_t ctrl2_word;
    ctrl_word_t sel_word;
    ctrl_word_t btn;
    logic       heartbeat;
    logic       present1;
    logic       present2;
    logic       unused_in;

    assign unused_in = &{1'b0, ena, uio_in, ui_in[7], ui_in[3:1]};

    gamepad_pmod_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .pmod_latch(ui_in[6]),
        .pmod_clk  (ui_in[5]),
        .pmod_data (ui_in[4]),
        .ctrl1_word(ctrl1_word),
        .ctrl2_word(ctrl2_word),
        .heartbeat (heartbeat)
    );

    assign present1 = (ctrl1_word != ABSENT_WORD);
    assign present2 = (ctrl2_word != ABSENT_WORD);

    // Absent controller reads all-ones; blank its buttons instead.
    always_comb begin
        sel_word = ui_in[0] ? ctrl2_word : ctrl1_word;
        btn      = '0;
        if (ui_in[0] ? present2 : present1) btn = sel_word;
    end

    assign uo_out  = btn[BTN_B:BTN_RIGHT];
    assign uio_out = {btn[BTN_A:BTN_R], present1, present2, ui_in[0], heartbeat};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_gamepad_pmod_demo.sv
// Self-checking bench for gamepad_pmod_demo with a frame-level model.
module tb_gamepad_pmod_demo;

    localparam int TO = 1000;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_pass;

    logic [11:0] m1, m2;
    logic        m_hb;
    logic        q[$];

    gamepad_pmod_demo #(.TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [11:0] sel_btn(input logic sel);
        logic [11:0] w;
        w = sel ? m2 : m1;
        return (w == 12'hFFF) ? 12'h000 : w;
    endfunction

    function automatic logic [7:0] exp_uo(input logic sel);
        logic [11:0] b;
        b = sel_btn(sel);
        return b[11:4];
    endfunction

    function automatic logic [7:0] exp_uio(input logic sel);
        logic [11:0] b;
        b = sel_btn(sel);
        return {b[3:0], m1 != 12'hFFF, m2 != 12'hFFF, sel, m_hb};
    endfunction

    task automatic model_reset();
        m1 = 12'hFFF;
        m2 = 12'hFFF;
        m_hb = 0;
        q.delete();
    endtask

    task automatic model_latch();
        if (q.size() == 24) begin
            for (int i = 0; i < 12; i++) begin
                m2[11-i] = q[i];
                m1[11-i] = q[12+i];
            end
            m_hb = ~m_hb;
        end
        q.delete();
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ui_in[5] = 0;
        ui_in[4] = b;
        repeat (2) @(negedge clk);
        ui_in[5] = 1;
        q.push_back(b);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_latch();
        @(negedge clk);
        ui_in[5] = 0;
        repeat (2) @(negedge clk);
        ui_in[6] = 1;
        model_latch();
        repeat (2) @(negedge clk);
        ui_in[6] = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [11:0] c2, input logic [11:0] c1, input int n);
        logic [23:0] w;
        w = {c2, c1};
        for (int i = 0; i < n; i++)
            send_bit(i < 24 ? w[23-i] : 1'($urandom_range(0, 1)));
        do_latch();
    endtask

    task automatic test_reset();
        ui_in = 0;
        uio_in = 0;
        ena = 1;
        rst_n = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL reset_uo got %h want 00", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== 8'h00) $display("FAIL reset_uio got %h want 00", uio_out);
        else n_pass++;
        n_checks++;
        if (uio_oe !== 8'hFF) $display("FAIL reset_oe got %h want FF", uio_oe);
        else n_pass++;
        ui_in[0] = 1;
        #1;
        n_checks++;
        if (uio_out !== 8'h02) $display("FAIL reset_sel_uio got %h want 02", uio_out);
        else n_pass++;
        @(negedge clk);
        ui_in[0] = 0;
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_valid_frame();
        ui_in[0] = 0;
        send_frame(12'hFFF, 12'h801, 24);
        n_checks++;
        if (uo_out !== 8'h80) $display("FAIL valid_uo got %h want 80", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== 8'h19) $display("FAIL valid_uio got %h want 19", uio_out);
        else n_pass++;
    endtask

    task automatic test_select();
        ui_in[0] = 1;
        send_frame(12'h0F0, 12'h000, 24);
        n_checks++;
        if (uo_out !== 8'h0F) $display("FAIL sel2_uo got %h want 0F", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== 8'h0E) $display("FAIL sel2_uio got %h want 0E", uio_out);
        else n_pass++;
        ui_in[0] = 0;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL sel1_uo got %h want 00", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== exp_uio(0)) $display("FAIL sel1_uio got %h want %h", uio_out, exp_uio(0));
        else n_pass++;
    endtask

    task automatic test_bad_frame();
        logic [7:0] uo0, uio0;
        uo0 = uo_out;
        uio0 = uio_out;
        send_frame(12'hABC, 12'h123, 23);
        n_checks++;
        if (uo_out !== uo0) $display("FAIL short_uo got %h want %h", uo_out, uo0);
        else n_pass++;
        n_checks++;
        if (uio_out !== uio0) $display("FAIL short_uio got %h want %h", uio_out, uio0);
        else n_pass++;
        send_frame(12'h5A5, 12'h3C3, 25);
        n_checks++;
        if (uio_out !== uio0) $display("FAIL long_uio got %h want %h", uio_out, uio0);
        else n_pass++;
        send_frame(12'h5A5, 12'h3C3, 24);
        n_checks++;
        if (uo_out !== 8'h3C) $display("FAIL after_bad_uo got %h want 3C", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== exp_uio(0)) $display("FAIL after_bad_uio got %h want %h", uio_out, exp_uio(0));
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [23:0] w;
        w = 24'h6E1_2B4;
        ui_in[0] = 1;
        for (int i = 0; i < 24; i++) send_bit(w[23-i]);
        @(negedge clk);
        ui_in[5] = 0;
        ui_in[4] = 1;
        repeat (3) @(negedge clk);
        ui_in[5] = 1;
        ui_in[6] = 1;
        model_latch();
        repeat (3) @(negedge clk);
        ui_in[6] = 0;
        ui_in[5] = 0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (uo_out !== 8'h6E) $display("FAIL simul_uo got %h want 6E", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== exp_uio(1)) $display("FAIL simul_uio got %h want %h", uio_out, exp_uio(1));
        else n_pass++;
        ui_in[0] = 0;
        #1;
        n_checks++;
        if (uo_out !== 8'h2B) $display("FAIL simul_c1_uo got %h want 2B", uo_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        @(negedge clk);
        ui_in[5] = 0;
        repeat (4) @(negedge clk);
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        do_latch();
        n_checks++;
        if (uo_out !== 8'h00) $display("FAIL midrst_uo got %h want 00", uo_out);
        else n_pass++;
        n_checks++;
        if (uio_out !== 8'h00) $display("FAIL midrst_uio got %h want 00", uio_out);
        else n_pass++;
    endtask

    task automatic test_random();
        int n;
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(0, 1) ? 24 : $urandom_range(20, 28);
            ui_in[0] = 1'($urandom_range(0, 1));
            send_frame(12'($urandom), 12'($urandom_range(0, 3) == 0 ? 12'hFFF : 12'($urandom)), n);
            n_checks++;
            if (uo_out !== exp_uo(ui_in[0]))
                $display("FAIL rand%0d_uo got %h want %h", k, uo_out, exp_uo(ui_in[0]));
            else n_pass++;
            n_checks++;
            if (uio_out !== exp_uio(ui_in[0]))
                $display("FAIL rand%0d_uio got %h want %h", k, uio_out, exp_uio(ui_in[0]));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        ui_in[0] = 0;
        send_frame(12'h0A0, 12'h00F, 24);
        repeat (TO + 100) @(negedge clk);
`ifdef GAMEPAD_TIMEOUT_EN
        m1 = 12'hFFF;
        m2 = 12'hFFF;
`endif
        n_checks++;
        if (uo_out !== exp_uo(0)) $display("FAIL hold_uo got %h want %h", uo_out, exp_uo(0));
        else n_pass++;
        n_checks++;
        if (uio_out !== exp_uio(0)) $display("FAIL hold_uio got %h want %h", uio_out, exp_uio(0));
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_valid_frame();
        test_select();
        test_bad_frame();
        test_simultaneous();
        test_random();
        test_hold();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
